// File: rtl/step_pkg.sv
// Shared definitions for the stepper command sequencer.
// Contents: FSM state encoding, maximum chunk magnitude, driver data width.
package step_pkg;

    localparam int DRV_W     = 8;           // signed chunk width on the driver bus
    localparam int CHUNK_MAX = 127;         // largest chunk magnitude (-128 never produced)
    localparam int CHUNK_W   = DRV_W - 1;   // unsigned chunk magnitude width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/step_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x W, with occupancy count and flush.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           clears pointers and level on the next edge (wins over push/pop)
//   push_i, data_i    write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   data_o            head entry
//   level_o           occupancy, 0..DEPTH
//   full_o, empty_o   derived from the registered level
module step_cmd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign data_o  = mem[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/step_cmd_sequencer.sv
// Stepper command sequencer: buffers signed move commands and splits each
// into chunks of at most 127 steps issued on the driver start/data/ready
// handshake.
// Optional feature macro: STEP_POS_TRACK_EN adds the absolute position
// register and the pos port.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     host handshake, transfer when both high
//   cmd_steps               signed move (zero moves are accepted and dropped)
//   flush                   empty FIFO and abandon the remainder of the move
//   drv_ready               driver idle
//   drv_start               one-cycle start pulse per chunk
//   drv_data                signed chunk, held until the next issue
//   busy                    work pending (FIFO, remainder or FSM not idle)
//   level                   FIFO occupancy
//   pos                     absolute position (STEP_POS_TRACK_EN only)
//   dbg_state               current FSM state
// Handshakes: the host side transfers on the rising edge where cmd_valid and
// cmd_ready are both high; the driver side issues a chunk only when
// drv_ready is high in IDLE and then waits in BUSY for drv_ready to return.
module step_cmd_sequencer
    import step_pkg::*;
#(
    parameter int CMD_W = 16,
    parameter int DEPTH = 8,
    parameter int POS_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CMD_W-1:0]         cmd_steps,
    input  logic                     flush,
    input  logic                     drv_ready,
    output logic                     drv_start,
    output logic [DRV_W-1:0]         drv_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
`ifdef STEP_POS_TRACK_EN
    output logic [POS_W-1:0]         pos,
`endif
    output logic [1:0]               dbg_state
);

    localparam int REM_W = CMD_W + 1;  // holds |-2^(CMD_W-1)| exactly

    state_e              state_q;
    logic                dir_q;        // 1 = reverse
    logic [REM_W-1:0]    rem_q;
    logic [CHUNK_W-1:0]  chunk_q;
    logic                drv_start_q;
    logic [DRV_W-1:0]    drv_data_q;
`ifdef STEP_POS_TRACK_EN
    logic [POS_W-1:0]    pos_q;
`endif

    logic                fifo_full;
    logic                fifo_empty;
    logic [CMD_W-1:0]    fifo_head;
    logic                push;
    logic                load;
    logic [REM_W-1:0]    head_ext;
    logic [REM_W-1:0]    head_mag;
    logic [CHUNK_W-1:0]  chunk_d;
    logic [DRV_W-1:0]    chunk_signed_d;

    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready & (cmd_steps != '0) & ~flush;
    assign load      = (state_q == ST_IDLE) && (rem_q == '0) && !fifo_empty && !flush;

    step_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (cmd_steps),
        .pop_i   (load),
        .data_o  (fifo_head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Magnitude is taken one bit wider so the most negative command is exact.
    assign head_ext = {fifo_head[CMD_W-1], fifo_head};
    assign head_mag = fifo_head[CMD_W-1] ? (REM_W'(0) - head_ext) : head_ext;

    assign chunk_d        = (rem_q > REM_W'(CHUNK_MAX)) ? CHUNK_W'(CHUNK_MAX) : rem_q[CHUNK_W-1:0];
    assign chunk_signed_d = dir_q ? (DRV_W'(0) - {1'b0, chunk_d}) : {1'b0, chunk_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            rem_q       <= '0;
            chunk_q     <= '0;
            drv_start_q <= 1'b0;
            drv_data_q  <= '0;
`ifdef STEP_POS_TRACK_EN
            pos_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drv_start_q <= 1'b0;
                    if (flush) begin
                        rem_q <= '0;
                    end else if (load) begin
                        dir_q <= fifo_head[CMD_W-1];
                        rem_q <= head_mag;
                    end else if ((rem_q != '0) && drv_ready) begin
                        chunk_q     <= chunk_d;
                        drv_data_q  <= chunk_signed_d;
                        drv_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    drv_start_q <= 1'b0;
                    rem_q       <= flush ? '0 : (rem_q - REM_W'(chunk_q));
                    state_q     <= ST_BUSY;
                end
                ST_BUSY: begin
                    drv_start_q <= 1'b0;
                    if (flush) rem_q <= '0;
                    if (drv_ready) begin
                        state_q <= ST_IDLE;
`ifdef STEP_POS_TRACK_EN
                        // Chunk is still on drv_data, so accumulate it on completion.
                        pos_q <= pos_q + {{(POS_W-DRV_W){drv_data_q[DRV_W-1]}}, drv_data_q};
`endif
                    end
                end
                default: begin
                    drv_start_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign drv_start = drv_start_q;
    assign drv_data  = drv_data_q;
    // The remainder is included so busy does not dip in the cycle after a load.
    assign busy      = !fifo_empty || (state_q != ST_IDLE) || (rem_q != '0);
    assign dbg_state = state_q;
`ifdef STEP_POS_TRACK_EN
    assign pos       = pos_q;
`endif

endmodule
